// File: rtl/spram_ctrl.sv
// spram_ctrl: valid/ready request front end that owns the port timing of one single-port RAM (registered q).
// Define SPRAM_CTRL_VERIFY_EN to add write read-back verification (verr / verr_addr ports).
module spram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_enable,
    input  logic [DATA_WIDTH-1:0] ram_q,
`ifdef SPRAM_CTRL_VERIFY_EN
    output logic                  verr,
    output logic [ADDR_WIDTH-1:0] verr_addr,
`endif
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAP   = 3'd2,
        RSP      = 3'd3
`ifdef SPRAM_CTRL_VERIFY_EN
        ,
        WV_ISSUE = 3'd4,
        WV_CAP   = 3'd5
`endif
    } state_t;

    state_t state, state_nxt;
    logic   wr_acc, rd_acc, rsp_hs;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nxt = state;
        req_ready = 1'b0;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                // Not ready while reset is asserted, so nothing is accepted in the reset cycle.
                req_ready = !rst;
                if (req_valid && !rst) begin
                    if (req_we) begin
                        wr_acc = 1'b1;
`ifdef SPRAM_CTRL_VERIFY_EN
                        state_nxt = WV_ISSUE;
`endif
                    end else begin
                        rd_acc    = 1'b1;
                        state_nxt = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_nxt = RD_CAP;
            RD_CAP:   state_nxt = RSP;
            RSP: begin
                if (rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef SPRAM_CTRL_VERIFY_EN
            WV_ISSUE: state_nxt = WV_CAP;
            WV_CAP:   state_nxt = IDLE;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_enable <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            // Enable is a single-cycle strobe: high only in the cycle after a write accept.
            ram_enable <= 1'b0;
            if (wr_acc) begin
                ram_addr   <= req_addr;
                ram_data   <= req_wdata;
                ram_enable <= 1'b1;
                wr_cnt     <= wr_cnt + CNT_WIDTH'(1);
            end
            if (rd_acc) ram_addr <= req_addr;
            if (state == RD_CAP) begin
                rsp_data  <= ram_q;
                rsp_valid <= 1'b1;
            end
            if (rsp_hs) begin
                rsp_valid <= 1'b0;
                rd_cnt    <= rd_cnt + CNT_WIDTH'(1);
            end
        end
    end

`ifdef SPRAM_CTRL_VERIFY_EN
    // The read-back issued while in WV_CAP lands on ram_q one edge later, so the compare is
    // deferred by a cycle; ram_addr/ram_data still hold the verified write at that point.
    logic v_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pending <= 1'b0;
            verr      <= 1'b0;
            verr_addr <= '0;
        end else begin
            v_pending <= (state == WV_CAP);
            if (v_pending && (ram_q != ram_data) && !verr) begin
                verr      <= 1'b1;
                verr_addr <= ram_addr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: randomized self-checking bench for spram_ctrl against a word-array reference model.
// Build with SPRAM_CTRL_VERIFY_EN defined to also exercise the write verify path.
module tb_spram_ctrl;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_enable;
    logic [DW-1:0] ram_q;
    logic [CW-1:0] wr_cnt, rd_cnt;
`ifdef SPRAM_CTRL_VERIFY_EN
    logic          verr;
    logic [AW-1:0] verr_addr;
`endif

    spram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_enable(ram_enable), .ram_q(ram_q),
`ifdef SPRAM_CTRL_VERIFY_EN
        .verr(verr), .verr_addr(verr_addr),
`endif
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: enable=1 writes, q registered; corrupt forces q to zero.
    logic [DW-1:0] ram_mem [64] = '{default: 8'h00};
    logic [DW-1:0] ram_q_raw = '0;
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (ram_enable) ram_mem[ram_addr] <= ram_data;
        ram_q_raw <= ram_mem[ram_addr];
    end
    assign ram_q = corrupt ? '0 : ram_q_raw;

    // Reference model: expected memory contents and transaction counts.
    logic [DW-1:0] ref_mem [64] = '{default: 8'h00};
    logic [CW-1:0] exp_wr = '0;
    logic [CW-1:0] exp_rd = '0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ram_enable must be high exactly in the cycle following a write handshake.
    logic mon_en = 1'b0;
    logic prev_acc = 1'b0;
    always @(negedge clk) begin
        #2;
        if (mon_en) check("en_rule", ram_enable, prev_acc);
        prev_acc = req_valid && req_ready && req_we;
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    task automatic write_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ref_mem[a] = d;
        exp_wr++;
        check("wr_en", ram_enable, 1);
        check("wr_addr", ram_addr, a);
        check("wr_data", ram_data, d);
    endtask

    task automatic read_req(input logic [AW-1:0] a, input int hold);
        int n;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = DW'($urandom);
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_busy", req_ready, 0);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_lat", n, 3);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, ref_mem[a]);
            check("hold_busy", req_ready, 0);
            @(negedge clk);
        end
        check("rsp_data", rsp_data, ref_mem[a]);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_rd++;
        check("rsp_done", rsp_valid, 0);
        check("rd_cnt", rd_cnt, exp_rd);
        check("rd_idle", req_ready, 1);
    endtask

    initial begin
        // Reset held for two cycles: all outputs zero, ready afterwards.
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_ram_en", ram_enable, 0);
            check("rst_ram_addr", ram_addr, 0);
            check("rst_ram_data", ram_data, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_cnts", {wr_cnt, rd_cnt}, 0);
        end
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        mon_en = 1'b1;

        write_req(6'h12, 8'hA5);
        read_req(6'h12, 0);

        // Back-to-back writes followed by in-order read-back.
        for (int i = 0; i < 4; i++) write_req(AW'(i), DW'(8'h11 * (i + 1)));
        check("wr_cnt4", wr_cnt, exp_wr);
        for (int i = 0; i < 4; i++) read_req(AW'(i), 0);

        // Response back-pressure for five cycles.
        read_req(6'h03, 5);

        // Reset while the read is in RD_CAP: response must never appear.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h03;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_wr = '0;
        exp_rd = '0;
        for (int i = 0; i < 4; i++) begin
            check("abort_rsp", rsp_valid, 0);
            check("abort_cnts", {wr_cnt, rd_cnt}, 0);
            @(negedge clk);
        end
        read_req(6'h00, 0);

        // Randomized mix of reads and writes with random back-pressure.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1, 0) == 1) write_req(AW'($urandom), DW'($urandom));
            else                           read_req(AW'($urandom), int'($urandom_range(2, 0)));
        end
        check("wr_cnt_end", wr_cnt, exp_wr);
        check("rd_cnt_end", rd_cnt, exp_rd);

`ifdef SPRAM_CTRL_VERIFY_EN
        check("verr_clean", verr, 0);
        corrupt = 1'b1;
        write_req(6'h3F, 8'h5A);
        repeat (4) @(negedge clk);
        corrupt = 1'b0;
        check("verr_set", verr, 1);
        check("verr_addr", verr_addr, 6'h3F);
        write_req(6'h01, 8'h77);
        write_req(6'h02, 8'h88);
        repeat (4) @(negedge clk);
        check("verr_sticky", verr, 1);
        check("verr_addr_kept", verr_addr, 6'h3F);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
